spw_ulight_nofifo_link_status: RTL and testbench
================================================

SPW_ULIGHT_NOFIFO_LINK_STATUS -- requirements
Module: spw_ulight_nofifo_link_status

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of link-status input bits, legal range 1..32.
REQ-002 The block SHALL have parameter EDGE_MODE, default 2: capture on 0 = rising, 1 = falling, 2 = any edge.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-006 The block SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-007 The block SHALL have port write_n, input, 1 bit: Avalon-MM write strobe, active low.
REQ-008 The block SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-009 The block SHALL have port in_port, input, WIDTH bits: asynchronous link-status bits from the SpaceWire core.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered Avalon-MM read data.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt to the CPU, active high.

Function
REQ-012 Register map SHALL be: 0 = DATA (RO, synchronized in_port), 1 = IRQMASK (RW, WIDTH bits), 2 = reserved (reads 0, writes ignored), 3 = EDGECAP (read; write-1-to-clear).
REQ-013 in_port SHALL pass through the input synchronizer into register sync_q; DATA SHALL return sync_q zero-extended to 32 bits.
REQ-014 Register prev_q SHALL capture sync_q every cycle; per-bit edge = rising (sync_q & ~prev_q), falling (~sync_q & prev_q) or any (sync_q ^ prev_q) per EDGE_MODE.
REQ-015 A detected edge SHALL set the corresponding EDGECAP bit on the next clock edge; set bits SHALL hold until cleared.
REQ-016 A write (chipselect=1, write_n=0, address=3) SHALL clear each EDGECAP bit whose writedata bit is 1.
REQ-017 When a clear and a new edge coincide on the same bit in the same cycle, set SHALL win and the bit SHALL remain 1.
REQ-018 A write to address 1 SHALL load IRQMASK from writedata[WIDTH-1:0]; writes to address 0 or 2 SHALL have no effect.
REQ-019 irq SHALL equal OR-reduction of (EDGECAP & IRQMASK), driven directly from those registers, no extra latency.
REQ-020 readdata SHALL be registered every cycle from the current address (read latency 1), bits 31..WIDTH always 0; reads SHALL have no side effects.
REQ-021 Out-of-range writedata bits above WIDTH-1 SHALL be ignored.

Reset
REQ-022 On reset_n=0, synchronizer stages, sync_q, prev_q, EDGECAP, IRQMASK and readdata SHALL clear to 0 asynchronously; irq SHALL be 0.
REQ-023 Because prev_q resets to 0, an in_port bit high at reset release SHALL register a rising/any edge after synchronizer latency; software clears it.
REQ-024 Reset asserted mid-operation SHALL discard pending edges and mask with no partial update.

Configuration
REQ-025 Macro SPW_LINK_STATUS_SYNC2_EN defined: in_port SHALL pass two flop stages before sync_q; DATA valid 2 cycles after an in_port change, EDGECAP 3 cycles.
REQ-026 SPW_LINK_STATUS_SYNC2_EN undefined: a single flop stage SHALL feed sync_q (for synchronous in_port); DATA valid 1 cycle after, EDGECAP 2 cycles.

Verification
REQ-027 Reset with in_port=0x00, read addresses 0..3 -> readdata 0x00000000 each, irq=0.
REQ-028 EDGE_MODE=2, SYNC2 defined: in_port 0x00->0x05 at cycle 0 -> DATA reads 0x05 from cycle 2, EDGECAP=0x05 from cycle 3; with IRQMASK=0x04 irq=1 from cycle 3.
REQ-029 EDGECAP=0x05, write 0x04 to address 3 -> EDGECAP=0x01, irq falls to 0 with IRQMASK=0x04.
REQ-030 Clear bit 0 in the same cycle a new edge reaches bit 0 -> EDGECAP bit 0 remains 1.
REQ-031 EDGE_MODE=0: in_port 0x01->0x00 -> EDGECAP unchanged; 0x00->0x01 -> EDGECAP bit 0 set.
REQ-032 Assert reset_n while EDGECAP=0xFF and IRQMASK=0xFF -> both 0, irq=0 immediately, without a clock edge.

Source files
------------

// File: rtl/spw_ulight_nofifo_link_status.sv
// ---------------------------------------------------------------------------
// spw_ulight_nofifo_link_status
//
// Avalon-MM slave that exposes the SpaceWire link-status bits to a CPU,
// latches edges on them and raises a level interrupt for unmasked edges.
//
// Parameters:
//   WIDTH     - number of link-status bits (1..32)
//   EDGE_MODE - 0 = rising, 1 = falling, 2 = any edge
//
// Build option:
//   SPW_LINK_STATUS_SYNC2_EN - when defined, in_port passes two flops
//   (meta_q, sync_q) for asynchronous inputs; otherwise sync_q samples
//   in_port directly.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous, active-low reset
//   address    - word address: 0 DATA, 1 IRQMASK, 2 reserved, 3 EDGECAP
//   chipselect - slave select
//   write_n    - write strobe, active low
//   writedata  - write data (bits above WIDTH-1 ignored)
//   in_port    - link-status bits from the SpaceWire core
//   readdata   - registered read data, latency 1, upper bits zero
//   irq        - OR of (EDGECAP & IRQMASK)
// ---------------------------------------------------------------------------
module spw_ulight_nofifo_link_status #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_MODE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_RSVD    = 2'd2,
    ADDR_EDGECAP = 2'd3
  } addr_e;

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] sync_d;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;

`ifdef SPW_LINK_STATUS_SYNC2_EN
  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
    end else begin
      meta_q <= in_port;
    end
  end

  assign sync_d = meta_q;
`else
  assign sync_d = in_port;
`endif

  always_comb begin
    case (EDGE_MODE)
      0:       edge_det = sync_q & ~prev_q;
      1:       edge_det = ~sync_q & prev_q;
      default: edge_det = sync_q ^ prev_q;
    endcase
  end

  always_comb begin
    clr_mask  = '0;
    irqmask_d = irqmask_q;
    if (wr_en && (addr_e'(address) == ADDR_EDGECAP)) begin
      clr_mask = writedata[WIDTH-1:0];
    end
    if (wr_en && (addr_e'(address) == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    // Set is OR-ed in after the clear so a coincident edge wins.
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (addr_e'(address))
      ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= sync_q;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_spw_ulight_nofifo_link_status.sv
// ---------------------------------------------------------------------------
// Bench for spw_ulight_nofifo_link_status: three instances (rising, falling,
// any edge) share one set of inputs. A history-based model predicts readdata
// and irq for each and is compared every falling clock edge; directed
// sequences pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_spw_ulight_nofifo_link_status;

`ifdef SPW_LINK_STATUS_SYNC2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd [3];
  logic        irq_w [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spw_ulight_nofifo_link_status #(.WIDTH(8), .EDGE_MODE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq_w[0]));

  spw_ulight_nofifo_link_status #(.WIDTH(8), .EDGE_MODE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq_w[1]));

  spw_ulight_nofifo_link_status #(.WIDTH(8), .EDGE_MODE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_w[2]));

  // ---------------- behavioural model ----------------
  // hist[k] is in_port as sampled k clock edges ago; the synchronized value
  // is hist[L-1] and its predecessor hist[L].
  logic [7:0]  hist [3];
  logic [7:0]  m_ecap [3];
  logic [7:0]  m_mask;
  logic [31:0] m_rd [3];

  function automatic logic [7:0] edge_of(int m, logic [7:0] cur, logic [7:0] prv);
    if (m == 0) return cur & ~prv;
    if (m == 1) return ~cur & prv;
    return cur ^ prv;
  endfunction

  function automatic logic [31:0] read_of(logic [1:0] a, logic [7:0] dat,
                                          logic [7:0] msk, logic [7:0] ec);
    case (a)
      2'd0:    return {24'h0, dat};
      2'd1:    return {24'h0, msk};
      2'd3:    return {24'h0, ec};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        hist[k]   <= 8'h0;
        m_ecap[k] <= 8'h0;
        m_rd[k]   <= 32'h0;
      end
      m_mask <= 8'h0;
    end else begin
      for (int m = 0; m < 3; m++) begin
        m_rd[m]   <= read_of(address, hist[L-1], m_mask, m_ecap[m]);
        m_ecap[m] <= (m_ecap[m] & ~((chipselect && !write_n && address == 2'd3)
                                    ? writedata[7:0] : 8'h0))
                     | edge_of(m, hist[L-1], hist[L]);
      end
      if (chipselect && !write_n && address == 2'd1) m_mask <= writedata[7:0];
      hist[0] <= in_port;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("model_rd[%0d]", m), rd[m], m_rd[m]);
      chk($sformatf("model_irq[%0d]", m), {31'h0, irq_w[m]},
          {31'h0, |(m_ecap[m] & m_mask)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_at(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 8'h00;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Reset state: all addresses read zero, no interrupt.
    for (int a = 0; a < 4; a++) begin
      rd_at(2'(a));
      chk($sformatf("reset_rd_a%0d", a), rd[2], 32'h0);
      chk("reset_irq", {31'h0, irq_w[2]}, 32'h0);
    end

    // Mask and edge capture latency.
    wr(2'd1, 32'hFFFF_FF04);
    rd_at(2'd1);
    chk("mask_readback", rd[2], 32'h0000_0004);
    address = 2'd0;
    in_port = 8'h05;
    repeat (L) tick();
    chk("irq_before_cap", {31'h0, irq_w[2]}, 32'h0);
    tick();
    chk("data_read", rd[2], 32'h0000_0005);
    chk("irq_after_cap", {31'h0, irq_w[2]}, 32'h1);
    rd_at(2'd3);
    chk("ecap_any", rd[2], 32'h0000_0005);
    chk("ecap_rise", rd[0], 32'h0000_0005);
    chk("ecap_fall", rd[1], 32'h0000_0000);

    // Write-1-to-clear bit 2.
    wr(2'd3, 32'h0000_0004);
    chk("irq_after_clear", {31'h0, irq_w[2]}, 32'h0);
    tick();
    chk("ecap_after_clear", rd[2], 32'h0000_0001);

    // Falling edge on bit 0: rising-mode instance unchanged.
    in_port = 8'h04;
    repeat (L + 2) tick();
    chk("rise_ignores_fall", rd[0], 32'h0000_0001);
    chk("fall_sees_fall", rd[1], 32'h0000_0001);
    wr(2'd3, 32'h0000_00FF);
    in_port = 8'h05;
    repeat (L + 2) tick();
    chk("rise_sees_rise", rd[0], 32'h0000_0001);
    chk("fall_ignores_rise", rd[1], 32'h0000_0000);

    // Clear of bit 0 coincides with a new edge reaching bit 0.
    in_port = 8'h04;
    repeat (L) tick();
    wr(2'd3, 32'h0000_0001);
    tick();
    chk("set_wins_any", rd[2], 32'h0000_0001);
    chk("clear_no_edge_rise", rd[0], 32'h0000_0000);
    chk("set_wins_fall", rd[1], 32'h0000_0001);

    // Fill EDGECAP and mask, then assert reset between clock edges.
    wr(2'd3, 32'h0000_00FF);
    wr(2'd1, 32'h0000_00FF);
    in_port = 8'hFB;
    repeat (L + 2) tick();
    chk("ecap_full", rd[2], 32'h0000_00FF);
    chk("irq_full", {31'h0, irq_w[2]}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_irq", {31'h0, irq_w[2]}, 32'h0);
    chk("async_rd", rd[2], 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    rd_at(2'd1);
    chk("mask_after_reset", rd[2], 32'h0);

    // Randomized traffic; in_port stays high across release above, so the
    // reset-release edge is covered by the model too.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom;
      if (i == 200) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
